// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage -- EX stage of the 5-stage pipelined RISC-V core.
//
// Selects forwarded operands, runs the 32-bit ALU (3-bit ALUControl, Zero
// flag), resolves branches/jumps, computes the branch target and registers
// the results into the EX/MEM pipeline register.
//
// Optional build macro: EXECUTE_STAGE_MUL_EN
//   When defined, ALUControlE=110 is a 32-cycle shift-add multiply that
//   stalls the pipeline via BusyE. When undefined, 110 is an undefined code
//   (result 0) and BusyE is tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   RegWriteE..ALUControlE   ID/EX control fields
//   RD1_E, RD2_E, Imm_Ext_E  operands from ID/EX
//   RD_E, PCE, PCPlus4E      destination register and PC values
//   ResultW                  writeback result (forwarding source)
//   ForwardA_E, ForwardB_E   forwarding selects from the hazard unit
//   PCSrcE, PCTargetE        combinational fetch redirect and target
//   BusyE                    combinational EX stall request
//   RegWriteM..ALU_ResultM   EX/MEM pipeline register outputs
// -----------------------------------------------------------------------------
module execute_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               RegWriteE,
   input  logic               MemWriteE,
   input  logic [1:0]         ResultSrcE,
   input  logic               JumpE,
   input  logic               BranchE,
   input  logic               ALUSrcE,
   input  logic [2:0]         ALUControlE,
   input  logic [XLEN-1:0]    RD1_E,
   input  logic [XLEN-1:0]    RD2_E,
   input  logic [XLEN-1:0]    Imm_Ext_E,
   input  logic [RADDR_W-1:0] RD_E,
   input  logic [XLEN-1:0]    PCE,
   input  logic [XLEN-1:0]    PCPlus4E,
   input  logic [XLEN-1:0]    ResultW,
   input  logic [1:0]         ForwardA_E,
   input  logic [1:0]         ForwardB_E,
   output logic               PCSrcE,
   output logic [XLEN-1:0]    PCTargetE,
   output logic               BusyE,
   output logic               RegWriteM,
   output logic               MemWriteM,
   output logic [1:0]         ResultSrcM,
   output logic [RADDR_W-1:0] RD_M,
   output logic [XLEN-1:0]    PCPlus4M,
   output logic [XLEN-1:0]    WriteDataM,
   output logic [XLEN-1:0]    ALU_ResultM
);

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_e;

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] ex_result;
   logic            zero;
   logic            busy;

   // Forwarding muxes; 11 falls back to the register file like 00.
   // NOTE: every always_comb assigns its outputs on all paths (defaults or a
   // default case arm) so no latch is inferred.
   always_comb begin
      case (ForwardA_E)
         2'b10:   src_a = ALU_ResultM;
         2'b01:   src_a = ResultW;
         default: src_a = RD1_E;
      endcase
      case (ForwardB_E)
         2'b10:   fwd_b = ALU_ResultM;
         2'b01:   fwd_b = ResultW;
         default: fwd_b = RD2_E;
      endcase
   end

   assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

   always_comb begin
      alu_res = '0;
      case (ALUControlE)
         ALU_ADD: alu_res = src_a + src_b;
         ALU_SUB: alu_res = src_a - src_b;
         ALU_AND: alu_res = src_a & src_b;
         ALU_OR:  alu_res = src_a | src_b;
         ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_res = '0;
      endcase
   end

   assign zero      = (alu_res == '0);
   assign PCSrcE    = JumpE | (BranchE & zero);
   assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXECUTE_STAGE_MUL_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_e;

   mul_state_e      state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            // Stall is raised on the decode itself so the MUL never reaches M early.
            if (rst && ALUControlE == 3'b110) begin
               busy     = 1'b1;
               state_d  = RUN;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = src_a;
               mplier_d = src_b;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = DONE;
         end
         // Unconditional return so the still-held 110 is not re-decoded here.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ex_result = (state_q == DONE) ? acc_q : alu_res;
`else
   assign busy      = 1'b0;
   assign ex_result = alu_res;
`endif

   assign BusyE = busy;

   // EX/MEM register. A stall loads a bubble: controls cleared, data held.
   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples pre-edge values (ALU_ResultM forwarding relies on it).
   always_ff @(posedge clk) begin
      if (!rst) begin
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         ResultSrcM  <= '0;
         RD_M        <= '0;
         PCPlus4M    <= '0;
         WriteDataM  <= '0;
         ALU_ResultM <= '0;
      end else if (busy) begin
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
      end else begin
         RegWriteM   <= RegWriteE;
         MemWriteM   <= MemWriteE;
         ResultSrcM  <= ResultSrcE;
         RD_M        <= RD_E;
         PCPlus4M    <= PCPlus4E;
         WriteDataM  <= fwd_b;
         ALU_ResultM <= ex_result;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage -- directed self-checking bench for execute_stage.
// Build with +define+EXECUTE_STAGE_MUL_EN to exercise the multiplier.
// -----------------------------------------------------------------------------
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE, ForwardA_E, ForwardB_E;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic        PCSrcE, BusyE, RegWriteM, MemWriteM;
   logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RD_M;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
      .ALU_ResultM(ALU_ResultM)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b11;
      JumpE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0; ALUControlE = 3'b000;
      RD1_E = 32'h11; RD2_E = 32'h22; Imm_Ext_E = 32'h33; RD_E = 5'd31;
      PCE = 32'h100; PCPlus4E = 32'h104; ResultW = 32'h44;
      ForwardA_E = 2'b00; ForwardB_E = 2'b00;

      // Reset held two cycles with live EX values.
      tick(); tick();
      check("rst_regwrite",  {31'b0, RegWriteM}, 32'd0);
      check("rst_memwrite",  {31'b0, MemWriteM}, 32'd0);
      check("rst_resultsrc", {30'b0, ResultSrcM}, 32'd0);
      check("rst_rd",        {27'b0, RD_M}, 32'd0);
      check("rst_pcplus4",   PCPlus4M, 32'd0);
      check("rst_wdata",     WriteDataM, 32'd0);
      check("rst_alu",       ALU_ResultM, 32'd0);
      check("rst_busy",      {31'b0, BusyE}, 32'd0);

      // Release: first edge captures plain ADD 0x0C + 0x04.
      rst = 1'b1; RD1_E = 32'h0C; RD2_E = 32'h04; ResultSrcE = 2'b10;
      RD_E = 5'd9; PCPlus4E = 32'h104;
      tick();
      check("cap_regwrite",  {31'b0, RegWriteM}, 32'd1);
      check("cap_memwrite",  {31'b0, MemWriteM}, 32'd1);
      check("cap_resultsrc", {30'b0, ResultSrcM}, 32'd2);
      check("cap_rd",        {27'b0, RD_M}, 32'd9);
      check("cap_pcplus4",   PCPlus4M, 32'h104);
      check("cap_wdata",     WriteDataM, 32'h04);
      check("cap_alu",       ALU_ResultM, 32'h10);

      // ADD with A forwarded from EX/MEM (0x10) plus immediate 3.
      RD1_E = 32'd5; RD2_E = 32'h55; ForwardA_E = 2'b10; ALUSrcE = 1'b1;
      Imm_Ext_E = 32'd3; MemWriteE = 1'b0; #1;
      check("add_pcsrc", {31'b0, PCSrcE}, 32'd0);
      tick();
      check("add_fwd_alu", ALU_ResultM, 32'h13);
      check("add_wdata",   WriteDataM, 32'h55);
      check("add_memwrite", {31'b0, MemWriteM}, 32'd0);

      // BEQ taken: A=7 from regfile, B=7 forwarded from ResultW.
      ForwardA_E = 2'b00; ForwardB_E = 2'b01; ALUSrcE = 1'b0; RD1_E = 32'd7;
      RD2_E = 32'h99; ResultW = 32'd7; ALUControlE = 3'b001; BranchE = 1'b1;
      PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF8; #1;
      check("beq_pcsrc",  {31'b0, PCSrcE}, 32'd1);
      check("beq_target", PCTargetE, 32'h0000_00F8);
      tick();
      check("beq_alu",   ALU_ResultM, 32'd0);
      check("beq_wdata", WriteDataM, 32'd7);

      // SUB 2-3, branch not taken.
      ForwardB_E = 2'b00; RD1_E = 32'd2; RD2_E = 32'd3; #1;
      check("sub_pcsrc", {31'b0, PCSrcE}, 32'd0);
      tick();
      check("sub_alu", ALU_ResultM, 32'hFFFF_FFFF);

      // SLT with the same operands.
      BranchE = 1'b0; ALUControlE = 3'b101;
      tick();
      check("slt_alu", ALU_ResultM, 32'd1);

      // AND, ForwardA=11 must select the regfile.
      ForwardA_E = 2'b11; RD1_E = 32'hF0; RD2_E = 32'h3C; ALUControlE = 3'b010;
      tick();
      check("and_fwd11", ALU_ResultM, 32'h30);

      // ADD with B forwarded from EX/MEM (0x30); store data follows forwarded B.
      ForwardA_E = 2'b00; ForwardB_E = 2'b10; RD1_E = 32'h5; RD2_E = 32'h0;
      ALUControlE = 3'b000;
      tick();
      check("addb_alu",   ALU_ResultM, 32'h35);
      check("addb_wdata", WriteDataM, 32'h30);

      // OR.
      ForwardB_E = 2'b00; RD1_E = 32'hF0; RD2_E = 32'h0F; ALUControlE = 3'b011;
      tick();
      check("or_alu", ALU_ResultM, 32'hFF);

      // Undefined codes give zero.
      ALUControlE = 3'b100;
      tick();
      check("undef100", ALU_ResultM, 32'd0);
      ALUControlE = 3'b011;
      tick();
      ALUControlE = 3'b111;
      tick();
      check("undef111", ALU_ResultM, 32'd0);
`ifndef EXECUTE_STAGE_MUL_EN
      ALUControlE = 3'b011;
      tick();
      ALUControlE = 3'b110; #1;
      check("undef110_busy", {31'b0, BusyE}, 32'd0);
      tick();
      check("undef110", ALU_ResultM, 32'd0);
`endif

      // JAL.
      ALUControlE = 3'b000; JumpE = 1'b1; RegWriteE = 1'b1; PCE = 32'h200;
      Imm_Ext_E = 32'h10; PCPlus4E = 32'h204; #1;
      check("jal_pcsrc",  {31'b0, PCSrcE}, 32'd1);
      check("jal_target", PCTargetE, 32'h210);
      tick();
      check("jal_pcplus4",  PCPlus4M, 32'h204);
      check("jal_regwrite", {31'b0, RegWriteM}, 32'd1);

      // Branch target wraps modulo 2^32.
      JumpE = 1'b0; PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h20; #1;
      check("target_wrap", PCTargetE, 32'h10);

      // Mid-stream reset clears M.
      rst = 1'b0;
      tick();
      check("rst2_regwrite", {31'b0, RegWriteM}, 32'd0);
      check("rst2_alu",      ALU_ResultM, 32'd0);
      rst = 1'b1;

`ifdef EXECUTE_STAGE_MUL_EN
      // Prime M with a known value, then MUL -3 * 7.
      RD1_E = 32'h5; RD2_E = 32'h6; ALUControlE = 3'b000; ALUSrcE = 1'b0;
      tick();
      check("mul_pre_alu", ALU_ResultM, 32'hB);
      RD1_E = 32'hFFFF_FFFD; RD2_E = 32'd7; ALUControlE = 3'b110; RD_E = 5'd12;
      PCPlus4E = 32'h308; #1;
      for (int i = 0; i < 33; i++) begin
         check($sformatf("mul_busy_%0d", i), {31'b0, BusyE}, 32'd1);
         tick();
         check($sformatf("mul_bubble_%0d", i), {31'b0, RegWriteM}, 32'd0);
         check($sformatf("mul_hold_%0d", i), ALU_ResultM, 32'hB);
      end
      check("mul_done_busy", {31'b0, BusyE}, 32'd0);
      tick();
      ALUControlE = 3'b000; #1;
      check("mul_result",   ALU_ResultM, 32'hFFFF_FFEB);
      check("mul_regwrite", {31'b0, RegWriteM}, 32'd1);
      check("mul_rd",       {27'b0, RD_M}, 32'd12);
      check("mul_idle_busy", {31'b0, BusyE}, 32'd0);

      // Reset in the middle of RUN.
      ALUControlE = 3'b110;
      for (int i = 0; i < 10; i++) tick();
      check("mul2_busy", {31'b0, BusyE}, 32'd1);
      rst = 1'b0;
      tick();
      check("mulrst_busy", {31'b0, BusyE}, 32'd0);
      check("mulrst_regwrite", {31'b0, RegWriteM}, 32'd0);
      check("mulrst_alu", ALU_ResultM, 32'd0);
      rst = 1'b1; ALUControlE = 3'b000; RD1_E = 32'd1; RD2_E = 32'd2; #1;
      check("mulrst_idle", {31'b0, BusyE}, 32'd0);
      tick();
      check("mulrst_after_add", ALU_ResultM, 32'd3);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
